alu_seq: RTL and testbench

//   Parametrised, handshaked successor to the combinational ALU. It keeps the

---
 rtl/alu_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops 0x0-0x9 plus iterative unsigned MUL/MULHU/DIVU/REMU.
// Results land in a registered output stage whose back-pressure gates new accepts.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);
  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ITER = 2'd1, ST_DONE = 2'd2} state_t;

  function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0]   res;
    logic [SHAMT_W-1:0] sh;
    sh = y[SHAMT_W-1:0];
    case (op)
      4'h0:    res = x + y;
      4'h1:    res = x - y;
      4'h2:    res = x & y;
      4'h3:    res = x | y;
      4'h4:    res = x ^ y;
      4'h5:    res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      4'h6:    res = x << sh;
      4'h7:    res = x >> sh;
      4'h8:    res = {{(WIDTH-1){1'b0}}, (x < y)};
      4'h9:    res = $unsigned($signed(x) >>> sh);
      default: res = {WIDTH{1'b0}};
    endcase
    return res;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [SHAMT_W-1:0] cnt_r, cnt_nxt_s;
  logic [3:0]         op_r, op_nxt_s;
  logic [WIDTH-1:0]   opnd_r, opnd_nxt_s;
  logic [WIDTH-1:0]   hi_r, hi_nxt_s;
  logic [WIDTH-1:0]   lo_r, lo_nxt_s;
  logic               out_valid_r, zero_r, illegal_r;
  logic [WIDTH-1:0]   result_r;
  logic               accept_s, is_multi_s, is_illegal_s;
  logic               load_s, load_illegal_s;
  logic [WIDTH-1:0]   load_result_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;

  assign in_ready     = (state_r == ST_IDLE) & (~out_valid_r | out_ready);
  assign accept_s     = in_valid & in_ready;
  assign is_multi_s   = (alu_op >= 4'hA) && (alu_op <= 4'hD);
  assign is_illegal_s = (alu_op >= 4'hE);

  // hi_r:lo_r is the 2*WIDTH product (multiplier in lo_r) or remainder:quotient
  assign mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
  assign div_shift_s = {hi_r, lo_r[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opnd_r};

  // Next-state, iteration datapath and output-stage load selection
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    op_nxt_s       = op_r;
    opnd_nxt_s     = opnd_r;
    hi_nxt_s       = hi_r;
    lo_nxt_s       = lo_r;
    load_s         = 1'b0;
    load_result_s  = {WIDTH{1'b0}};
    load_illegal_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_multi_s) begin
          state_nxt_s = ST_ITER;
          cnt_nxt_s   = SHAMT_W'(WIDTH - 1);
          op_nxt_s    = alu_op;
          hi_nxt_s    = {WIDTH{1'b0}};
          lo_nxt_s    = alu_op[2] ? a : b;
          opnd_nxt_s  = alu_op[2] ? b : a;
        end else if (accept_s) begin
          load_s         = 1'b1;
          load_result_s  = alu_single(alu_op, a, b);
          load_illegal_s = is_illegal_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (op_r[2]) begin
          if (!div_diff_s[WIDTH]) begin
            hi_nxt_s = div_diff_s[WIDTH-1:0];
            lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
          end else begin
            hi_nxt_s = div_shift_s[WIDTH-1:0];
            lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
          end
        end else begin
          hi_nxt_s = mul_sum_s[WIDTH:1];
          lo_nxt_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end
        if (cnt_r == {SHAMT_W{1'b0}}) begin
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s = cnt_r - {{(SHAMT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        load_s        = 1'b1;
        load_result_s = op_r[0] ? hi_r : lo_r;
        state_nxt_s   = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM and iteration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {SHAMT_W{1'b0}};
      op_r    <= 4'h0;
      opnd_r  <= {WIDTH{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      op_r    <= op_nxt_s;
      opnd_r  <= opnd_nxt_s;
      hi_r    <= hi_nxt_s;
      lo_r    <= lo_nxt_s;
    end
  end

  // Output stage: a new load wins over a same-edge transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      result_r    <= load_result_s;
      zero_r      <= (load_result_s == {WIDTH{1'b0}});
      illegal_r   <= load_illegal_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;
  assign illegal   = illegal_r;
  assign busy      = (state_r == ST_ITER);
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, zero, illegal, busy;
  logic [31:0] a = 32'd0, b = 32'd0, result;
  logic [3:0]  alu_op = 4'd0;
  logic        in_valid_8 = 1'b0, out_ready_8 = 1'b1;
  logic        in_ready_8, out_valid_8, zero_8, illegal_8, busy_8;
  logic [7:0]  a_8 = 8'd0, b_8 = 8'd0, result_8;
  logic [3:0]  alu_op_8 = 4'd0;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal), .busy(busy));

  alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .a(a_8), .b(b_8), .alu_op(alu_op_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
    .result(result_8), .zero(zero_8), .illegal(illegal_8), .busy(busy_8));

  // Reference: plain arithmetic on 64-bit values, masked to w bits
  function automatic longint unsigned model(input int w, input logic [3:0] op,
                                            input longint unsigned x, input longint unsigned y);
    longint unsigned mask, r;
    longint signed   sx, sy;
    int              sh;
    mask = (64'd1 << w) - 64'd1;
    sh   = int'(y % longint'(w));
    sx   = ((x >> (w - 1)) & 64'd1) != 0 ? longint'(x) - longint'(64'd1 << w) : longint'(x);
    sy   = ((y >> (w - 1)) & 64'd1) != 0 ? longint'(y) - longint'(64'd1 << w) : longint'(y);
    case (op)
      4'h0: r = x + y;
      4'h1: r = x - y;
      4'h2: r = x & y;
      4'h3: r = x | y;
      4'h4: r = x ^ y;
      4'h5: r = (sx < sy) ? 64'd1 : 64'd0;
      4'h6: r = x << sh;
      4'h7: r = x >> sh;
      4'h8: r = (x < y) ? 64'd1 : 64'd0;
      4'h9: r = $unsigned(sx >>> sh);
      4'hA: r = x * y;
      4'hB: r = (x * y) >> w;
      4'hC: r = (y == 64'd0) ? mask : x / y;
      4'hD: r = (y == 64'd0) ? x : x % y;
      default: r = 64'd0;
    endcase
    return r & mask;
  endfunction

  task automatic run32(input logic [3:0] op, input logic [31:0] xa, input logic [31:0] xb,
                       output logic [31:0] r, output logic zr, output logic il,
                       output int lat, output int bcnt, output logic ok);
    int guard;
    in_valid = 1'b1; alu_op = op; a = xa; b = xb; guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; alu_op = 4'($urandom);
    lat = 0; bcnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1; lat++;
    end
    ok = out_valid; r = result; zr = zero; il = illegal;
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] xa, input logic [7:0] xb,
                      output logic [7:0] r, output int lat, output int bcnt, output logic ok);
    int guard;
    in_valid_8 = 1'b1; alu_op_8 = op; a_8 = xa; b_8 = xb; guard = 0;
    @(negedge clk);
    while (!in_ready_8 && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    in_valid_8 = 1'b0; a_8 = 8'($urandom); b_8 = 8'($urandom);
    lat = 0; bcnt = 0;
    while (!out_valid_8 && lat < 100) begin
      if (busy_8) bcnt++;
      @(posedge clk); #1; lat++;
    end
    ok = out_valid_8; r = result_8;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_ctl: out_valid=%b busy=%b want 0 0", out_valid, busy); end
    n_cmp++; if (result !== 32'd0 || zero !== 1'b0 || illegal !== 1'b0) begin n_err++; $display("FAIL reset_out: result=%h zero=%b illegal=%b want 0 0 0", result, zero, illegal); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [3:0]  ops [10] = '{4'h0, 4'h1, 4'h5, 4'h8, 4'h9, 4'h6, 4'hC, 4'hD, 4'hC, 4'hD};
    logic [31:0] as  [10] = '{32'hFFFFFFF6, 32'd20, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd8, 32'd100, 32'd100, 32'h12345678, 32'd5};
    logic [31:0] bs  [10] = '{32'd20, 32'd20, 32'd1, 32'd1, 32'd4, 32'h22, 32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] exp [10] = '{32'd10, 32'd0, 32'd1, 32'd0, 32'hF8000000, 32'd32, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5};
    logic [31:0] r; logic zr, il, ok; int lat, bc, elat;
    for (int i = 0; i < 10; i++) begin
      run32(ops[i], as[i], bs[i], r, zr, il, lat, bc, ok);
      elat = (ops[i] >= 4'hA) ? 33 : 0;
      n_cmp++; if (!ok || r !== exp[i] || zr !== (exp[i] == 32'd0)) begin n_err++; $display("FAIL directed_%0d op=%h: result=%h zero=%b want %h %b", i, ops[i], r, zr, exp[i], exp[i] == 32'd0); end
      n_cmp++; if (lat != elat) begin n_err++; $display("FAIL directed_lat_%0d: latency=%0d want %0d", i, lat, elat); end
    end
  endtask

  task automatic test_mul();
    logic [31:0] r; logic zr, il, ok; int lat, bc;
    run32(4'hA, 32'h7FFFFFFF, 32'd2, r, zr, il, lat, bc, ok);
    n_cmp++; if (!ok || r !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mul: result=%h want fffffffe", r); end
    run32(4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, r, zr, il, lat, bc, ok);
    n_cmp++; if (!ok || r !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mulhu: result=%h want fffffffe", r); end
    n_cmp++; if (bc != 32 || lat != 33) begin n_err++; $display("FAIL mulhu_timing: busy=%0d lat=%0d want 32 33", bc, lat); end
  endtask

  task automatic test_random();
    logic [31:0] xa, xb, r, e; logic [3:0] op; logic zr, il, ok; int lat, bc, elat;
    for (int i = 0; i < 120; i++) begin
      op = 4'($urandom_range(15, 0)); xa = $urandom; xb = $urandom;
      case ($urandom_range(7, 0))
        0: xb = 32'd0;
        1: xa = 32'd0;
        2: xb = xa;
        3: xb = $urandom_range(15, 1);
        default: ;
      endcase
      e = 32'(model(32, op, longint'(xa), longint'(xb)));
      elat = (op >= 4'hA && op <= 4'hD) ? 33 : 0;
      run32(op, xa, xb, r, zr, il, lat, bc, ok);
      n_cmp++; if (!ok || r !== e || zr !== (e == 32'd0) || il !== (op >= 4'hE) || lat != elat) begin
        n_err++; $display("FAIL random_%0d op=%h a=%h b=%h: result=%h zero=%b illegal=%b lat=%0d want %h %b %b %0d",
          i, op, xa, xb, r, zr, il, lat, e, e == 32'd0, op >= 4'hE, elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [$]; logic [31:0] xa, xb, e; logic [3:0] op;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) begin
        e = q.pop_front();
        n_cmp++; if (out_valid !== 1'b1 || result !== e) begin n_err++; $display("FAIL b2b_%0d: out_valid=%b result=%h want 1 %h", i, out_valid, result, e); end
      end
      if (i < 20) begin
        op = 4'($urandom_range(11, 0)); if (op >= 4'hA) op = op + 4'd4;
        xa = $urandom; xb = $urandom;
        alu_op = op; a = xa; b = xb;
        q.push_back(32'(model(32, op, longint'(xa), longint'(xb))));
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] e2;
    out_ready = 1'b0;
    in_valid = 1'b1; alu_op = 4'h0; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    e2 = 32'(model(32, 4'h4, 64'h0F0F1234, 64'h00FF00FF));
    alu_op = 4'h4; a = 32'h0F0F1234; b = 32'h00FF00FF;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || result !== 32'd11 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL stall_%0d: out_valid=%b result=%h in_ready=%b want 1 0000000b 0", i, out_valid, result, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release: in_ready=%b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || result !== e2) begin n_err++; $display("FAIL stall_replace: out_valid=%b result=%h want 1 %h", out_valid, result, e2); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r; logic zr, il, ok; int lat, bc, seen;
    in_valid = 1'b1; alu_op = 4'hC; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy: busy=%b want 1", busy); end
    #2 rst_n = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_mid: out_valid=%b busy=%b want 0 0", out_valid, busy); end
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid || busy) seen++; end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rst_no_result: active_cycles=%0d want 0", seen); end
    run32(4'h0, 32'd3, 32'd4, r, zr, il, lat, bc, ok);
    n_cmp++; if (!ok || r !== 32'd7 || lat != 0) begin n_err++; $display("FAIL rst_after_add: result=%h lat=%0d want 7 0", r, lat); end
  endtask

  task automatic test_width8();
    logic [7:0] r, xa, xb, e; logic [3:0] op; logic ok; int lat, bc, elat;
    run8(4'hA, 8'h10, 8'h10, r, lat, bc, ok);
    n_cmp++; if (!ok || r !== 8'h00) begin n_err++; $display("FAIL w8_mul: result=%h want 00", r); end
    run8(4'hB, 8'h10, 8'h10, r, lat, bc, ok);
    n_cmp++; if (!ok || r !== 8'h01 || lat != 9 || bc != 8) begin n_err++; $display("FAIL w8_mulhu: result=%h lat=%0d busy=%0d want 01 9 8", r, lat, bc); end
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(15, 0)); xa = 8'($urandom); xb = 8'($urandom);
      if (i % 6 == 0) xb = 8'd0;
      e = 8'(model(8, op, longint'(xa), longint'(xb)));
      elat = (op >= 4'hA && op <= 4'hD) ? 9 : 0;
      run8(op, xa, xb, r, lat, bc, ok);
      n_cmp++; if (!ok || r !== e || lat != elat) begin
        n_err++; $display("FAIL w8_random_%0d op=%h a=%h b=%h: result=%h lat=%0d want %h %0d", i, op, xa, xb, r, lat, e, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_op();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
